alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
Shares the single 32-bit combinational Alu (A, B, ALU_Sel, ALU_Out, coutfin, z) between N_REQ requesters using round-robin arbitration. It accepts one operation per grant and registers the operands into the Alu. It captures ALU_Out, coutfin and z into a response register and returns them with the winning requester's id over a valid/ready response channel. It sits between the issue logic and the Alu, which it instantiates.

Parameters:
N_REQ, 2, number of requesters; legal range 2..4.
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= N_REQ.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  N_REQ  per-requester request valid.
req_ready  out  N_REQ  per-requester grant; at most one bit is high.
req_a  in  N_REQ*32  operand A; slice i belongs to requester i.
req_b  in  N_REQ*32  operand B; slice i belongs to requester i.
req_op  in  N_REQ*4  ALU_Sel code; slice i belongs to requester i.
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts the response.
rsp_id  out  ID_W  index of the requester that issued the operation.
rsp_result  out  32  captured ALU_Out.
rsp_cout  out  1  captured coutfin.
rsp_z  out  1  captured z.
busy  out  1  high whenever state is not IDLE.
ops_done  out  CNT_W  count of accepted responses; wraps to 0.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: the one-hot grant to the first valid requester, searching from ptr upward and wrapping.
  - On a grant (req_valid[i] & req_ready[i]): latch req_a/b/op slice i into opA/opB/opSel; latch i into id_q; set ptr = (i+1) mod N_REQ; go to EXEC.
  - No valid request: remain in IDLE.
- EXEC:
  - The Alu is driven only from opA/opB/opSel.
  - At the end of the cycle, capture ALU_Out, coutfin and z into the response registers; go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_id, rsp_result, rsp_cout and rsp_z stay stable until rsp_valid & rsp_ready.
  - On acceptance: ops_done += 1 (wraps at 2**CNT_W); go to IDLE.
- Latency and throughput:
  - Grant in cycle T gives rsp_valid high in cycle T+2.
  - With rsp_ready held high, one operation completes every 3 cycles.
  - No grant is issued in EXEC or RESP; req_ready is all-zero there.
- Round-robin rules:
  - After reset ptr = 0, so requester 0 has the highest priority.
  - A requester that continuously holds req_valid is granted within N_REQ grants.
  - Simultaneous requests: the lowest index at or above ptr wins.
- Requesters hold req_valid and their payload until granted. The scheduler does not rely on this: a valid dropped before its grant is simply not serviced.
- Backpressure: rsp_ready low in RESP stalls indefinitely, with no loss and no output change.
- Reset, including mid-operation:
  - state = IDLE, ptr = 0, req_ready = 0.
  - rsp_valid = 0; rsp_id, rsp_result, rsp_cout and rsp_z = 0.
  - busy = 0, ops_done = 0, opA/opB/opSel = 0.
  - Any in-flight operation is discarded.
- The scheduler does not interpret ALU_Sel; the code is passed through unchanged.

Decomposition:
- Package alu_sched_pkg:
  - state enum {IDLE, EXEC, RESP}.
  - Opcode constant ALU_ADD = 4'b0010.
  - ALU_DW = 32 and ALU_SW = 4.
  - N_REQ_MAX = 4.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot gnt[N] and gnt_idx.
  - Purely combinational; the ptr register lives in the scheduler.
- The Alu is instantiated unchanged inside alu_rr_scheduler.

Test Plan:
- Reset then single request: requester 0 sends op=ALU_ADD, a=5, b=7. Required: req_ready[0] in the same cycle, rsp_valid 2 cycles later, result=0x0000000C, cout=0, z=0, id=0, ops_done=1.
- Carry and zero flags: a=0xFFFFFFFF, b=0x00000001, ALU_ADD. Required: result=0, cout=1, z=1.
- Contention: both requesters hold valid for 4 operations. Required: grant order 0,1,0,1; rsp_id sequence 0,1,0,1; ops_done=4.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. Required: response fields stable, req_ready=0, busy=1; accepted on the first rsp_ready=1 cycle.
- Reset mid-op: assert rst during EXEC. Required next cycle: rsp_valid=0, busy=0, ops_done=0, ptr=0; the following request from requester 1 completes normally.
- Counter wrap (CNT_W=4): 16 accepted responses. Required: ops_done returns to 0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin Alu scheduler.
package alu_sched_pkg;

  localparam int ALU_DW    = 32;
  localparam int ALU_SW    = 4;
  localparam int N_REQ_MAX = 4;

  localparam logic [ALU_SW-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_SW-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_SW-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_SW-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_SW-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_SW-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_SW-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/Alu.sv
// 32-bit combinational Alu; coutfin is the adder carry-out (no-borrow for SUB).
module Alu
  import alu_sched_pkg::*;
(
  input  logic [ALU_DW-1:0] A,
  input  logic [ALU_DW-1:0] B,
  input  logic [ALU_SW-1:0] ALU_Sel,
  output logic [ALU_DW-1:0] ALU_Out,
  output logic              coutfin,
  output logic              z
);

  logic [ALU_DW:0] sum;
  logic [ALU_DW:0] diff;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} + {1'b0, ~B} + {{ALU_DW{1'b0}}, 1'b1};

  always_comb begin
    ALU_Out = '0;
    coutfin = 1'b0;
    case (ALU_Sel)
      ALU_AND: ALU_Out = A & B;
      ALU_OR:  ALU_Out = A | B;
      ALU_XOR: ALU_Out = A ^ B;
      ALU_NOR: ALU_Out = ~(A | B);
      ALU_ADD: {coutfin, ALU_Out} = sum;
      ALU_SUB: {coutfin, ALU_Out} = diff;
      ALU_SLT: ALU_Out = {{(ALU_DW-1){1'b0}}, ($signed(A) < $signed(B))};
      default: ALU_Out = '0;
    endcase
  end

  assign z = (ALU_Out == '0);

endmodule

// File: rtl/alu_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (en && !found && (j == ((int'(ptr) + k) % N)) && req[j]) begin
          found   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin sharing of one Alu between N_REQ requesters with a valid/ready response port.
// States: IDLE = arbitrate and latch operands | EXEC = Alu evaluates | RESP = hold response until accepted
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ALU_DW-1:0]   req_a,
  input  logic [N_REQ*ALU_DW-1:0]   req_b,
  input  logic [N_REQ*ALU_SW-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [ALU_DW-1:0]         rsp_result,
  output logic                      rsp_cout,
  output logic                      rsp_z,
  output logic                      busy,
  output logic [CNT_W-1:0]          ops_done
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d, gnt_idx;
  logic [N_REQ-1:0]    gnt;
  logic                arb_en;
  logic [ALU_DW-1:0]   opa_q, opa_d, opb_q, opb_d, res_q, res_d, alu_out;
  logic [ALU_SW-1:0]   opsel_q, opsel_d;
  logic                cout_q, cout_d, z_q, z_d, alu_cout, alu_z;
  logic [CNT_W-1:0]    ops_done_q, ops_done_d;

  // Gating with rst keeps req_ready low while reset is held.
  assign arb_en = (state_q == IDLE) && !rst;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  Alu u_alu (
    .A       (opa_q),
    .B       (opb_q),
    .ALU_Sel (opsel_q),
    .ALU_Out (alu_out),
    .coutfin (alu_cout),
    .z       (alu_z)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    opsel_d    = opsel_q;
    res_d      = res_q;
    cout_d     = cout_q;
    z_d        = z_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              opa_d   = req_a[i*ALU_DW +: ALU_DW];
              opb_d   = req_b[i*ALU_DW +: ALU_DW];
              opsel_d = req_op[i*ALU_SW +: ALU_SW];
            end
          end
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_out;
        cout_d  = alu_cout;
        z_d     = alu_z;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      opsel_q    <= '0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      z_q        <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      opsel_q    <= opsel_d;
      res_q      <= res_d;
      cout_q     <= cout_d;
      z_q        <= z_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign req_ready  = gnt;
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_cout   = cout_q;
  assign rsp_z      = z_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench: vector table plus scoreboarded corner-case sequences.
module tb_alu_rr_scheduler;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_cout, rsp_z, busy;
  logic [3:0]  ops_done;

  logic [31:0] a_r [2];
  logic [31:0] b_r [2];
  logic [3:0]  op_r [2];

  assign req_a  = {a_r[1], a_r[0]};
  assign req_b  = {b_r[1], b_r[0]};
  assign req_op = {op_r[1], op_r[0]};

  always #5 clk = ~clk;

  alu_rr_scheduler #(.N_REQ(2), .ID_W(2), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_z      (rsp_z),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        c;
    logic        z;
  } rsp_t;

  typedef struct {
    logic [1:0]  vm;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  op0, op1;
    int          gi;
    logic [31:0] res;
    logic        c;
    logic        z;
  } vec_t;

  rsp_t       sb[$];
  logic [3:0] exp_cnt = '0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void alu_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                                    output logic [31:0] r, output logic c, output logic zz);
    r = '0;
    c = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; c = (r < a); end
      OP_SUB: begin r = a - b; c = (a >= b); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    zz = (r == 32'd0);
  endfunction

  // Every negedge: drop scoreboard on reset, otherwise compare an accepted response.
  task automatic nedge();
    rsp_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
    end else if (rsp_valid === 1'b1 && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_cout", rsp_cout, e.c);
        chk("rsp_z", rsp_z, e.z);
        chk("ops_done_pre", ops_done, exp_cnt);
        exp_cnt = exp_cnt + 4'd1;
      end
    end
  endtask

  task automatic push_exp(input int gi, input logic [31:0] r, input logic c, input logic zz);
    rsp_t e;
    e.id  = 2'(gi);
    e.res = r;
    e.c   = c;
    e.z   = zz;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] vm, input int gi, input logic [31:0] r, input logic c, input logic zz);
    @(posedge clk); #1 req_valid = vm;
    nedge();
    chk("gnt", req_ready, 64'd1 << gi);
    chk("busy_idle", busy, 0);
    push_exp(gi, r, c, zz);
    @(posedge clk); #1 req_valid = '0;
    nedge();
    chk("lat_t1_valid", rsp_valid, 0);
    chk("exec_no_gnt", req_ready, 0);
    chk("exec_busy", busy, 1);
    nedge();
    chk("lat_t2_valid", rsp_valid, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; req_valid = 2'b11;
    @(posedge clk);
    nedge();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_z", rsp_z, 0);
    @(posedge clk); #1 rst = 1'b0; req_valid = '0;
  endtask

  vec_t        tv [10];
  logic [31:0] mr;
  logic        mc, mz;
  int          g, last, gexp;

  initial begin
    for (int i = 0; i < 2; i++) begin
      a_r[i] = '0; b_r[i] = '0; op_r[i] = '0;
    end
    //            vm     a0            b0            a1            b1            op0     op1     gi res           c     z
    tv[0] = '{2'b01, 32'd5,        32'd7,        32'd0,        32'd0,        OP_ADD, OP_ADD, 0, 32'h0000000C, 1'b0, 1'b0};
    tv[1] = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        OP_ADD, OP_ADD, 0, 32'h00000000, 1'b1, 1'b1};
    tv[2] = '{2'b10, 32'd0,        32'd0,        32'd10,       32'd3,        OP_ADD, OP_SUB, 1, 32'h00000007, 1'b1, 1'b0};
    tv[3] = '{2'b11, 32'hF0F01234, 32'h0FF0FF00, 32'd9,        32'd9,        OP_AND, OP_ADD, 0, 32'h00F01200, 1'b0, 1'b0};
    tv[4] = '{2'b11, 32'd1,        32'd1,        32'h80000000, 32'h80000000, OP_ADD, OP_ADD, 1, 32'h00000000, 1'b1, 1'b1};
    tv[5] = '{2'b10, 32'd0,        32'd0,        32'd3,        32'd10,       OP_ADD, OP_SUB, 1, 32'hFFFFFFF9, 1'b0, 1'b0};
    tv[6] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd4,        32'd4,        OP_SLT, OP_ADD, 0, 32'h00000001, 1'b0, 1'b0};
    tv[7] = '{2'b01, 32'h00001234, 32'h00001234, 32'd0,        32'd0,        OP_XOR, OP_ADD, 0, 32'h00000000, 1'b0, 1'b1};
    tv[8] = '{2'b11, 32'd2,        32'd2,        32'h0F0F0000, 32'h00000F0F, OP_ADD, OP_OR,  1, 32'h0F0F0F0F, 1'b0, 1'b0};
    tv[9] = '{2'b11, 32'd0,        32'd0,        32'd5,        32'd5,        OP_NOR, OP_ADD, 0, 32'hFFFFFFFF, 1'b0, 1'b0};

    do_reset();

    for (int v = 0; v < 10; v++) begin
      a_r[0] = tv[v].a0; b_r[0] = tv[v].b0; op_r[0] = tv[v].op0;
      a_r[1] = tv[v].a1; b_r[1] = tv[v].b1; op_r[1] = tv[v].op1;
      issue(tv[v].vm, tv[v].gi, tv[v].res, tv[v].c, tv[v].z);
      if (v == 0) begin
        @(posedge clk);
        nedge();
        chk("ops_done_first", ops_done, 1);
      end
    end

    // Contention: both held valid, back-to-back with rsp_ready high.
    do_reset();
    a_r[0] = 32'd100;        b_r[0] = 32'd23; op_r[0] = OP_ADD;
    a_r[1] = 32'hFFFFFFFF;   b_r[1] = 32'd2;  op_r[1] = OP_ADD;
    rsp_ready = 1'b1;
    @(posedge clk); #1 req_valid = 2'b11;
    g = 0;
    last = 0;
    for (int c = 0; c < 60 && !(g == 4 && sb.size() == 0); c++) begin
      nedge();
      if (req_ready != 2'b00) begin
        gexp = g % 2;
        chk("cont_gnt", req_ready, 64'd1 << gexp);
        if (g > 0) chk("cont_gap", 64'(c - last), 3);
        last = c;
        alu_model(a_r[gexp], b_r[gexp], op_r[gexp], mr, mc, mz);
        push_exp(gexp, mr, mc, mz);
        g++;
        if (g == 4) begin
          @(posedge clk); #1 req_valid = '0;
        end
      end
    end
    chk("cont_grants", 64'(g), 4);
    @(posedge clk);
    nedge();
    chk("cont_ops_done", ops_done, 4);

    // Backpressure: response held while rsp_ready is low, no grant in the meantime.
    rsp_ready = 1'b0;
    a_r[1] = 32'd7; b_r[1] = 32'd9; op_r[1] = OP_ADD;
    issue(2'b10, 1, 32'd16, 1'b0, 1'b0);
    @(posedge clk); #1 req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      nedge();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_result", rsp_result, 32'd16);
      chk("bp_cout", rsp_cout, 0);
      chk("bp_busy", busy, 1);
      chk("bp_no_gnt", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1; req_valid = '0;
    nedge();
    @(posedge clk);
    nedge();
    chk("bp_idle_after", busy, 0);
    chk("bp_ops_done", ops_done, 5);

    // Reset while the Alu stage is active: in-flight op is discarded.
    a_r[0] = 32'd1; b_r[0] = 32'd2; op_r[0] = OP_ADD;
    @(posedge clk); #1 req_valid = 2'b01;
    nedge();
    chk("rm_gnt", req_ready, 1);
    push_exp(0, 32'd3, 1'b0, 1'b0);
    @(posedge clk); #1 req_valid = '0; rst = 1'b1;
    nedge();
    chk("rm_in_exec", busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    nedge();
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ops_done", ops_done, 0);
    chk("rm_rsp_result", rsp_result, 0);

    // After reset ptr is 0 again, so requester 0 beats requester 1.
    a_r[0] = 32'h11; b_r[0] = 32'h22; op_r[0] = OP_ADD;
    a_r[1] = 32'h1000; b_r[1] = 32'h1; op_r[1] = OP_SUB;
    issue(2'b11, 0, 32'h33, 1'b0, 1'b0);
    issue(2'b10, 1, 32'h0FFF, 1'b1, 1'b0);

    // Fourteen more to make 16 since reset; the 4-bit counter wraps to 0.
    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < 2; i++) begin
        a_r[i] = $urandom();
        b_r[i] = $urandom();
        op_r[i] = OP_ADD;
      end
      gexp = k % 2;
      alu_model(a_r[gexp], b_r[gexp], OP_ADD, mr, mc, mz);
      rsp_ready = 1'b1;
      issue(2'b11, gexp, mr, mc, mz);
    end
    @(posedge clk);
    nedge();
    chk("wrap_ops_done", ops_done, 0);
    chk("sb_drain", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
